// File: rtl/ring_step_ctrl.sv
// ---------------------------------------------------------------------------
// ring_step_ctrl
//   Command sequencer that sits directly upstream of the 8-bit ring counter.
//   It accepts LOAD / STEP_UP / STEP_DN / RUN commands over a valid/ready
//   handshake and produces the counter's Enable, Load, Up1Dn0 and Data
//   inputs. Steps are paced by a programmable prescaler: one step every
//   Divisor+1 clocks. Done pulses for one cycle when an operation completes
//   or is halted.
//
// Ports
//   Clock     in   1      rising-edge clock
//   Reset     in   1      asynchronous, active-high reset
//   CmdValid  in   1      command present
//   CmdReady  out  1      block can accept a command (idle and not halted)
//   CmdOp     in   2      00 LOAD, 01 STEP_UP, 10 STEP_DN, 11 RUN
//   CmdArg    in   8      LOAD: pattern; STEP: step count N; RUN: bit0 dir
//   Divisor   in   DIV_W  prescale D, sampled when a command is accepted
//   Halt      in   1      aborts STEP/RUN; blocks command acceptance
//   Enable    out  1      ring counter Enable (registered)
//   Load      out  1      ring counter Load (registered)
//   Up1Dn0    out  1      ring counter direction (registered)
//   Data      out  8      ring counter parallel load data (registered)
//   Busy      out  1      an operation is in progress
//   Done      out  1      one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module ring_step_ctrl #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             CmdValid,
   output logic             CmdReady,
   input  logic [1:0]       CmdOp,
   input  logic [7:0]       CmdArg,
   input  logic [DIV_W-1:0] Divisor,
   input  logic             Halt,
   output logic             Enable,
   output logic             Load,
   output logic             Up1Dn0,
   output logic [7:0]       Data,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_STEP = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_STEP_UP = 2'b01;
   localparam logic [1:0] OP_STEP_DN = 2'b10;
   localparam logic [1:0] OP_RUN     = 2'b11;

   localparam logic [DIV_W-1:0] PRE_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           state_q, state_n;
   logic [DIV_W-1:0] div_q,   div_n;    // divisor captured at accept
   logic [DIV_W-1:0] pre_q,   pre_n;    // prescaler phase, 0..div_q
   logic [CNT_W-1:0] cnt_q,   cnt_n;    // steps not yet issued
   logic             en_q,    en_n;
   logic             load_q,  load_n;
   logic             dir_q,   dir_n;
   logic [7:0]       data_q,  data_n;
   logic             done_q,  done_n;

   logic             accept;
   logic [DIV_W-1:0] pre_wrap;
   logic [CNT_W-1:0] arg_cnt;

   assign CmdReady = (state_q == S_IDLE) && !Halt;
   assign Busy     = (state_q != S_IDLE);
   assign Enable   = en_q;
   assign Load     = load_q;
   assign Up1Dn0   = dir_q;
   assign Data     = data_q;
   assign Done     = done_q;

   assign accept   = CmdValid && CmdReady;
   assign arg_cnt  = CmdArg[CNT_W-1:0];
   // Next prescaler phase while stepping: counts 0..D then wraps.
   assign pre_wrap = (pre_q == div_q) ? '0 : pre_q + PRE_ONE;

   // Next-state / next-output logic. Every output register is computed here
   // so that each pulse lands exactly in the cycle after its scheduling edge.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_n = state_q;
      div_n   = div_q;
      pre_n   = pre_q;
      cnt_n   = cnt_q;
      en_n    = 1'b0;
      load_n  = 1'b0;
      dir_n   = dir_q;
      data_n  = data_q;
      done_n  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               div_n = Divisor;
               pre_n = '0;
               unique case (CmdOp)
                  OP_LOAD: begin
                     state_n = S_LOAD;
                     en_n    = 1'b1;
                     load_n  = 1'b1;
                     data_n  = CmdArg;
                  end
                  OP_STEP_UP, OP_STEP_DN: begin
                     state_n = S_STEP;
                     dir_n   = (CmdOp == OP_STEP_UP);
                     // Phase 0 is already the pulse phase when D=0.
                     if ((Divisor == '0) && (arg_cnt != '0)) begin
                        en_n  = 1'b1;
                        cnt_n = arg_cnt - CNT_ONE;
                     end else begin
                        cnt_n = arg_cnt;
                     end
                  end
                  OP_RUN: begin
                     state_n = S_RUN;
                     dir_n   = CmdArg[0];
                     en_n    = (Divisor == '0);
                  end
                  default: ;
               endcase
            end
         end

         // The single load cycle is already on the outputs; finish now.
         // Halt is deliberately not looked at here.
         S_LOAD: begin
            state_n = S_IDLE;
            done_n  = 1'b1;
         end

         S_STEP: begin
            if (Halt || (cnt_q == '0)) begin
               // Either aborted or the last pulse has just been issued.
               state_n = S_IDLE;
               done_n  = 1'b1;
            end else begin
               pre_n = pre_wrap;
               if (pre_wrap == div_q) begin
                  en_n  = 1'b1;
                  cnt_n = cnt_q - CNT_ONE;
               end
            end
         end

         S_RUN: begin
            if (Halt) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end else begin
               pre_n = pre_wrap;
               en_n  = (pre_wrap == div_q);
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of block ordering.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: every register here is control state, so all of it is reset;
         // an operation in flight is simply discarded.
         state_q <= S_IDLE;
         div_q   <= '0;
         pre_q   <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         load_q  <= 1'b0;
         dir_q   <= 1'b1;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         div_q   <= div_n;
         pre_q   <= pre_n;
         cnt_q   <= cnt_n;
         en_q    <= en_n;
         load_q  <= load_n;
         dir_q   <= dir_n;
         data_q  <= data_n;
         done_q  <= done_n;
      end
   end

endmodule

// File: tb/tb_ring_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ring_step_ctrl
//   Scoreboard bench for ring_step_ctrl. The driver issues commands; for each
//   accepted command a reference model turns the command, its divisor and an
//   optional halt edge into the list of absolute cycles at which an Enable
//   pulse or Done pulse must appear, and pushes those events onto a queue.
//   A monitor on the falling edge pops and compares whenever the DUT shows
//   Enable or Done, and also checks Busy/CmdReady against the model's busy
//   window.
// ---------------------------------------------------------------------------
module tb_ring_step_ctrl;

   localparam int DIV_W = 16;
   localparam int CNT_W = 8;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             CmdValid;
   logic             CmdReady;
   logic [1:0]       CmdOp;
   logic [7:0]       CmdArg;
   logic [DIV_W-1:0] Divisor;
   logic             Halt;
   logic             Enable;
   logic             Load;
   logic             Up1Dn0;
   logic [7:0]       Data;
   logic             Busy;
   logic             Done;

   ring_step_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .CmdValid(CmdValid),
      .CmdReady(CmdReady),
      .CmdOp   (CmdOp),
      .CmdArg  (CmdArg),
      .Divisor (Divisor),
      .Halt    (Halt),
      .Enable  (Enable),
      .Load    (Load),
      .Up1Dn0  (Up1Dn0),
      .Data    (Data),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   // Edge counter: after rising edge number k, cyc == k.
   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         at;      // cycle (edge number) after which the event shows
      bit         pulse;   // 1: Enable pulse, 0: Done pulse
      bit         load;
      logic [7:0] data;
      bit         up;
   } ev_t;

   ev_t  sb[$];
   logic [7:0] m_data = 8'h00;
   bit         m_up   = 1'b1;
   int         b_start = 0;   // busy in cycles [b_start, b_end)
   int         b_end   = 0;

   task automatic add_ev(input int at, input bit pulse, input bit load);
      ev_t e;
      e.at = at; e.pulse = pulse; e.load = load; e.data = m_data; e.up = m_up;
      sb.push_back(e);
   endtask

   // h = relative edge at which Halt is sampled high (0 = no halt).
   task automatic model_op(input int e0, input logic [1:0] op, input logic [7:0] arg,
                           input int d, input int h, output int done_at);
      int n_steps;
      int stop;
      if (op == 2'b00) begin
         m_data = arg;
         add_ev(e0, 1'b1, 1'b1);
         done_at = e0 + 1;
      end else begin
         if (op == 2'b11) begin
            m_up = arg[0];
            stop = h;                       // RUN only ends by Halt
            n_steps = h;                    // more than enough candidates
         end else begin
            m_up = (op == 2'b01);
            n_steps = int'(arg);
            stop = (n_steps == 0) ? 1 : n_steps * (d + 1);
            if (h > 0 && h < stop) stop = h;
         end
         for (int n = 1; n <= n_steps; n++)
            if (n * (d + 1) - 1 < stop) add_ev(e0 + n * (d + 1) - 1, 1'b1, 1'b0);
         done_at = e0 + stop;
      end
      add_ev(done_at, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   ev_t ev;
   bit  busy_exp;
   always @(negedge Clock) begin
      if (!Reset) begin
         busy_exp = (cyc >= b_start) && (cyc < b_end);
         check("busy", Busy, busy_exp);
         check("cmd_ready", CmdReady, !busy_exp && !Halt);
         if (Enable || Done) begin
            if (sb.size() == 0) begin
               check("unexpected_event", {30'd0, Enable, Done}, 32'd0);
            end else begin
               ev = sb.pop_front();
               check("ev_cycle",  cyc,    ev.at);
               check("ev_enable", Enable, ev.pulse);
               check("ev_done",   Done,   !ev.pulse);
               check("ev_load",   Load,   ev.load);
               check("ev_data",   Data,   ev.data);
               check("ev_dir",    Up1Dn0, ev.up);
            end
         end else if (sb.size() > 0 && sb[0].at <= cyc) begin
            check("missed_event", {30'd0, Enable, Done}, sb[0].pulse ? 32'd2 : 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [1:0] op, input logic [7:0] arg, input int d, input int h);
      int e0;
      int done_at;
      @(negedge Clock); #1;
      CmdOp = op; CmdArg = arg; Divisor = DIV_W'(d); CmdValid = 1'b1;
      e0 = cyc + 1;
      model_op(e0, op, arg, d, h, done_at);
      b_start = e0; b_end = done_at;
      @(negedge Clock); #1;
      CmdValid = 1'b0;
      // Mid-op changes on the command bus and divisor must have no effect.
      CmdOp = 2'($urandom); CmdArg = 8'($urandom); Divisor = DIV_W'($urandom);
      if (h > 0) begin
         while (cyc < e0 + h - 1) begin @(negedge Clock); #1; end
         Halt = 1'b1;
         @(negedge Clock); #1;
         Halt = 1'b0;
      end
      while (cyc < done_at) begin @(negedge Clock); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int done_at;
      logic [1:0] op;
      int d;
      int n;
      int h;
      Reset = 1'b1; CmdValid = 1'b0; CmdOp = 2'b00; CmdArg = 8'h00;
      Divisor = '0; Halt = 1'b0;
      repeat (3) @(negedge Clock);
      #1 Reset = 1'b0;
      #1;
      // Reset state
      check("rst_ready",  CmdReady, 1'b1);
      check("rst_dir",    Up1Dn0,   1'b1);
      check("rst_data",   Data,     8'h00);
      check("rst_enable", Enable,   1'b0);
      check("rst_load",   Load,     1'b0);
      check("rst_done",   Done,     1'b0);
      check("rst_busy",   Busy,     1'b0);

      // Directed scenarios
      send(2'b00, 8'h01, 0, 0);    // LOAD 01
      send(2'b01, 8'd3,  0, 0);    // STEP_UP N=3 D=0
      send(2'b10, 8'd2,  3, 0);    // STEP_DN N=2 D=3
      send(2'b11, 8'h01, 1, 5);    // RUN up D=1, Halt at E5
      send(2'b01, 8'd0,  2, 0);    // STEP N=0
      send(2'b00, 8'hA5, 4, 1);    // LOAD with Halt at E1: ignored
      send(2'b10, 8'd4,  1, 3);    // STEP halted before it finishes
      send(2'b11, 8'h00, 0, 4);    // RUN down D=0

      // Halt held with CmdValid: no accept until Halt drops
      @(negedge Clock); #1;
      Halt = 1'b1; CmdValid = 1'b1; CmdOp = 2'b00; CmdArg = 8'h3C; Divisor = '0;
      repeat (4) begin @(negedge Clock); #1; end
      Halt = 1'b0;
      e0 = cyc + 1;
      model_op(e0, 2'b00, 8'h3C, 0, 0, done_at);
      b_start = e0; b_end = done_at;
      @(negedge Clock); #1;
      CmdValid = 1'b0;
      while (cyc < done_at) begin @(negedge Clock); #1; end

      // Reset in the middle of STEP_UP N=10 D=2, during a pulse
      @(negedge Clock); #1;
      CmdOp = 2'b01; CmdArg = 8'd10; Divisor = 16'd2; CmdValid = 1'b1;
      e0 = cyc + 1;
      model_op(e0, 2'b01, 8'd10, 2, 0, done_at);
      b_start = e0; b_end = done_at;
      @(negedge Clock); #1;
      CmdValid = 1'b0;
      while (cyc < e0 + 8) begin @(negedge Clock); #1; end
      Reset = 1'b1;
      #1;
      check("mid_rst_enable", Enable,   1'b0);
      check("mid_rst_load",   Load,     1'b0);
      check("mid_rst_dir",    Up1Dn0,   1'b1);
      check("mid_rst_data",   Data,     8'h00);
      check("mid_rst_busy",   Busy,     1'b0);
      check("mid_rst_done",   Done,     1'b0);
      check("mid_rst_ready",  CmdReady, 1'b1);
      sb.delete();
      b_start = 0; b_end = 0; m_data = 8'h00; m_up = 1'b1;
      repeat (2) @(negedge Clock);
      #1 Reset = 1'b0;
      repeat (40) @(negedge Clock);   // any Enable here is unexpected

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         d  = $urandom_range(0, 3);
         h  = 0;
         if (op == 2'b00) begin
            send(op, 8'($urandom), d, 0);
         end else if (op == 2'b11) begin
            send(op, 8'($urandom), d, $urandom_range(1, 20));
         end else begin
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 2) == 0)
               h = $urandom_range(1, (n == 0) ? 1 : n * (d + 1));
            send(op, 8'(n), d, h);
         end
      end

      repeat (5) @(negedge Clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
